gray_counter_ud: RTL and testbench

- Parametrised up/down Gray-code counter.
- Adds to the basic Gray counter: count enable, direction, synchronous load, wrap or saturate mode, and a terminal-count flag.
- Output comes straight from a register, so it is glitch-free and safe to pass across clock domains (e.g. async FIFO pointers, position encoders).

---
 rtl/gray_counter_ud.sv | 77 +++++++
 tb/tb_gray_counter_ud.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_ud.sv
// Up/down Gray-code counter with enable, synchronous load, wrap/saturate mode and terminal-count flag.
// Optional macro GRAY_COUNTER_BIN_OUT_EN adds the bin_out port exposing the registered binary count.
module gray_counter_ud #(
  parameter int unsigned           DATA_WIDTH = 4,
  parameter int unsigned           WRAP       = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_BIN   = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_bin,
  output logic [DATA_WIDTH-1:0] out,
`ifdef GRAY_COUNTER_BIN_OUT_EN
  output logic [DATA_WIDTH-1:0] bin_out,
`endif
  output logic                  tc
);

  localparam logic [DATA_WIDTH-1:0] MAX_BIN  = '1;
  localparam logic [DATA_WIDTH-1:0] ZERO_BIN = '0;
  localparam logic [DATA_WIDTH-1:0] ONE_BIN  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

  logic [DATA_WIDTH-1:0] bin_q,  bin_d;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic                  tc_q,   tc_d;

  logic [DATA_WIDTH-1:0] step_bin;
  logic                  at_max;
  logic                  at_min;
  logic                  at_limit;

  assign at_max   = (bin_q == MAX_BIN);
  assign at_min   = (bin_q == ZERO_BIN);
  assign at_limit = dir ? at_max : at_min;
  assign step_bin = dir ? (bin_q + ONE_BIN) : (bin_q - ONE_BIN);

  // A step at the limit is a wrap in wrap mode and a blocked request in
  // saturate mode; both raise tc, only saturate mode suppresses the move.
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      tc_d = at_limit;
      if ((WRAP != 0) || !at_limit) begin
        bin_d = step_bin;
      end
    end
  end

  assign gray_d = bin_d ^ (bin_d >> 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  // Outputs come straight from flops so they are safe to synchronise elsewhere.
  assign out = gray_q;
  assign tc  = tc_q;

`ifdef GRAY_COUNTER_BIN_OUT_EN
  assign bin_out = bin_q;
`endif

endmodule

// File: tb/tb_gray_counter_ud.sv
// Self-checking bench for gray_counter_ud: three instances (wrap/init 0, saturate/init 0, wrap/init 3)
// share one stimulus stream; a per-instance model fills expected queues that are popped after each edge.
module tb_gray_counter_ud;

  localparam int W  = 4;
  localparam int EW = 2 * W + 1;

  logic         clk;
  logic         resetn;
  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_bin;

  logic [W-1:0] out_w, out_s, out_i;
  logic         tc_w, tc_s, tc_i;
  logic [W-1:0] bin_w, bin_s, bin_i;

  int n_checks;
  int n_fail;

  logic [EW-1:0] exp_w_q[$];
  logic [EW-1:0] exp_s_q[$];
  logic [EW-1:0] exp_i_q[$];
  logic [W-1:0]  m_bin[3];

  gray_counter_ud #(.DATA_WIDTH(W), .WRAP(1), .INIT_BIN(4'd0)) dut_w (
    .clk(clk), .resetn(resetn), .en(en), .dir(dir), .load(load), .load_bin(load_bin),
    .out(out_w),
`ifdef GRAY_COUNTER_BIN_OUT_EN
    .bin_out(bin_w),
`endif
    .tc(tc_w)
  );

  gray_counter_ud #(.DATA_WIDTH(W), .WRAP(0), .INIT_BIN(4'd0)) dut_s (
    .clk(clk), .resetn(resetn), .en(en), .dir(dir), .load(load), .load_bin(load_bin),
    .out(out_s),
`ifdef GRAY_COUNTER_BIN_OUT_EN
    .bin_out(bin_s),
`endif
    .tc(tc_s)
  );

  gray_counter_ud #(.DATA_WIDTH(W), .WRAP(1), .INIT_BIN(4'd3)) dut_i (
    .clk(clk), .resetn(resetn), .en(en), .dir(dir), .load(load), .load_bin(load_bin),
    .out(out_i),
`ifdef GRAY_COUNTER_BIN_OUT_EN
    .bin_out(bin_i),
`endif
    .tc(tc_i)
  );

`ifndef GRAY_COUNTER_BIN_OUT_EN
  assign bin_w = '0;
  assign bin_s = '0;
  assign bin_i = '0;
`endif

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reference behaviour: returns {bin, tc, gray} after one edge.
  function automatic logic [EW-1:0] model_next(input int idx, input logic l,
                                               input logic [W-1:0] lb, input logic e,
                                               input logic d);
    logic [W-1:0] b, nb;
    logic         t;
    bit           wrap;
    wrap = (idx != 1);
    b    = m_bin[idx];
    nb   = b;
    t    = 1'b0;
    if (l) begin
      nb = lb;
    end else if (e) begin
      if (d) begin
        if (b == 4'hF) begin
          t  = 1'b1;
          nb = wrap ? 4'h0 : 4'hF;
        end else begin
          nb = b + 4'd1;
        end
      end else begin
        if (b == 4'h0) begin
          t  = 1'b1;
          nb = wrap ? 4'hF : 4'h0;
        end else begin
          nb = b - 4'd1;
        end
      end
    end
    m_bin[idx] = nb;
    return {nb, t, gray(nb)};
  endfunction

  task automatic model_reset();
    m_bin[0] = 4'd0;
    m_bin[1] = 4'd0;
    m_bin[2] = 4'd3;
  endtask

  task automatic compare(input string pfx, input int idx, input logic [W-1:0] o,
                         input logic t, input logic [W-1:0] b);
    logic [EW-1:0] e;
    int            depth;
    case (idx)
      0:       depth = exp_w_q.size();
      1:       depth = exp_s_q.size();
      default: depth = exp_i_q.size();
    endcase
    if (depth == 0) begin
      check({pfx, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      case (idx)
        0:       e = exp_w_q.pop_front();
        1:       e = exp_s_q.pop_front();
        default: e = exp_i_q.pop_front();
      endcase
      check({pfx, "_out"}, {28'd0, o}, {28'd0, e[W-1:0]});
      check({pfx, "_tc"}, {31'd0, t}, {31'd0, e[W]});
`ifdef GRAY_COUNTER_BIN_OUT_EN
      check({pfx, "_bin"}, {28'd0, b}, {28'd0, e[EW-1:W+1]});
`else
      if (b !== '0) check({pfx, "_bin_tied"}, {28'd0, b}, 32'd0);
`endif
    end
  endtask

  // driver: apply inputs on the falling edge, compare 1 time unit after the rising edge
  task automatic drive(input logic l, input logic [W-1:0] lb, input logic e, input logic d);
    @(negedge clk);
    load     = l;
    load_bin = lb;
    en       = e;
    dir      = d;
    exp_w_q.push_back(model_next(0, l, lb, e, d));
    exp_s_q.push_back(model_next(1, l, lb, e, d));
    exp_i_q.push_back(model_next(2, l, lb, e, d));
    @(posedge clk);
    #1;
    compare("w", 0, out_w, tc_w, bin_w);
    compare("s", 1, out_s, tc_s, bin_s);
    compare("i", 2, out_i, tc_i, bin_i);
  endtask

  logic [W-1:0] plan_up[16];
  logic [W-1:0] prev_w, prev_i;
  logic         r_l, r_e, r_d;
  logic [W-1:0] r_lb;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    plan_up  = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    resetn   = 1'b0;
    en       = 1'b0;
    dir      = 1'b1;
    load     = 1'b0;
    load_bin = '0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_w_out", {28'd0, out_w}, 32'h0);
    check("rst_s_out", {28'd0, out_s}, 32'h0);
    check("rst_i_out", {28'd0, out_i}, 32'h2);
    check("rst_tc", {29'd0, tc_w, tc_s, tc_i}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // full up sweep with wrap
    for (int k = 0; k < 16; k++) begin
      prev_w = out_w;
      drive(1'b0, 4'h0, 1'b1, 1'b1);
      check("plan_up_out", {28'd0, out_w}, {28'd0, plan_up[k]});
      check("plan_up_tc", {31'd0, tc_w}, (k == 15) ? 32'd1 : 32'd0);
      check("plan_up_hamming", $countones(out_w ^ prev_w), 32'd1);
    end

    // down through zero
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    check("down_wrap_out", {28'd0, out_w}, 32'h8);
    check("down_wrap_tc", {31'd0, tc_w}, 32'd1);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    check("down_next_out", {28'd0, out_w}, 32'h9);
    check("down_next_tc", {31'd0, tc_w}, 32'd0);

    // load beats enable
    drive(1'b1, 4'h5, 1'b1, 1'b1);
    check("load_prio_out", {28'd0, out_w}, 32'h7);
    check("load_prio_tc", {31'd0, tc_w}, 32'd0);
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    check("after_load_out", {28'd0, out_w}, 32'h5);

    // saturate at max
    drive(1'b1, 4'hE, 1'b0, 1'b1);
    check("sat_load_out", {28'd0, out_s}, 32'h9);
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    check("sat_reach_out", {28'd0, out_s}, 32'h8);
    check("sat_reach_tc", {31'd0, tc_s}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b1);
      check("sat_hold_out", {28'd0, out_s}, 32'h8);
      check("sat_hold_tc", {31'd0, tc_s}, 32'd1);
    end
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    check("sat_back_out", {28'd0, out_s}, 32'h9);
    check("sat_back_tc", {31'd0, tc_s}, 32'd0);

    // idle with dir toggling
    drive(1'b1, 4'h4, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'h0, 1'b0, k[0]);
      check("idle_out", {28'd0, out_w}, 32'h6);
      check("idle_tc", {31'd0, tc_w}, 32'd0);
    end

    // direction reversal: up to 3 then down
    drive(1'b1, 4'h1, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    check("reverse_out", {28'd0, out_w}, {28'd0, gray(4'd2)});

    // random traffic
    for (int k = 0; k < 300; k++) begin
      r_l    = ($urandom_range(0, 11) == 0);
      r_lb   = 4'($urandom_range(0, 15));
      r_e    = ($urandom_range(0, 3) != 0);
      r_d    = 1'($urandom_range(0, 1));
      prev_w = out_w;
      prev_i = out_i;
      drive(r_l, r_lb, r_e, r_d);
      if (r_e && !r_l) begin
        check("rnd_hamming_w", $countones(out_w ^ prev_w), 32'd1);
        check("rnd_hamming_i", $countones(out_i ^ prev_i), 32'd1);
      end else if (!r_l) begin
        check("rnd_idle_w", {28'd0, out_w}, {28'd0, prev_w});
      end
    end

    // asynchronous reset mid-count
    drive(1'b1, 4'h8, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    check("pre_rst_i_out", {28'd0, out_i}, 32'hD);
    #2;
    resetn = 1'b0;
    en     = 1'b0;
    #1;
    check("async_rst_i_out", {28'd0, out_i}, 32'h2);
    check("async_rst_w_out", {28'd0, out_w}, 32'h0);
    check("async_rst_tc", {29'd0, tc_w, tc_s, tc_i}, 32'd0);
`ifdef GRAY_COUNTER_BIN_OUT_EN
    check("async_rst_i_bin", {28'd0, bin_i}, 32'd3);
`endif
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    check("post_rst_i_out", {28'd0, out_i}, 32'h6);
`ifdef GRAY_COUNTER_BIN_OUT_EN
    check("post_rst_i_bin", {28'd0, bin_i}, 32'd4);
`endif
    drive(1'b0, 4'h0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
